ibex_icache_core_protocol_checker: RTL and testbench
====================================================

Name: ibex_icache_core_protocol_checker

Overview:
- Passive protocol checker bound beside the core-side port of the instruction cache; observes only and never drives the cache or the core.
- Each cycle it evaluates 8 protocol rules: core-to-cache branch/req rules and cache-to-core valid/address/stability rules.
- Reports violations as registered per-rule pulses plus sticky status bits.
- Sits inside the core-side agent interface; fully synthesizable (no X checks).

Parameters:
CHECK_MASK, 8'hFF, per-rule enable; bit i=0 suppresses rule i (pulse and sticky stay 0).

Ports:
clk  in  1  clock; all sampling on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  1  core enabled/requesting
branch  in  1  branch request (single-cycle pulse)
branch_spec  in  1  speculative branch; observed only, no rule
branch_addr  in  32  branch target
ready  in  1  core accepts instruction
valid  in  1  cache presents instruction
rdata  in  32  instruction data
addr  in  32  instruction address
err  in  1  fetch error
err_plus2  in  1  error lies in upper half of instruction
enable  in  1  cache enable; observed only
invalidate  in  1  invalidate request; observed only
busy  in  1  cache busy; observed only
fail_o  out  8  registered one-cycle pulse per violated rule
fail_sticky_o  out  8  OR-accumulated fail_o; cleared only by reset
fail_any_o  out  1  OR of fail_sticky_o

Behaviour:
- Reset (async, rst_n=0): fail_o=0, fail_sticky_o=0, fail_any_o=0, all tracking state cleared; seen_branch=0, exp_valid=0.
- Handshake (hs) = valid & ready & ~branch. Any valid in a branch cycle is ignored for rules 2, 4, 5 and 7.
- Tracking state:
  - On branch: exp_addr<=branch_addr, exp_valid<=1, seen_branch<=1.
  - On hs with err=0: exp_addr<=addr + (rdata[1:0]==2'b11 ? 4 : 2), with 32-bit wrap.
  - On hs with err=1: exp_valid<=0 until the next branch.
- Hold state: on every cycle, registers prev_hold = valid & ~ready & ~branch and captures addr, rdata, err, err_plus2.
- Rules, evaluated at cycle t; fail_o[i] asserts at t+1 for exactly one cycle:
  - 0 BRANCH_ALIGN: branch & branch_addr[0].
  - 1 BRANCH_NO_REQ: branch & ~req.
  - 2 VALID_ALIGN: valid & ~branch & addr[0].
  - 3 VALID_DROP: prev_hold & ~valid. valid may only drop after a handshake or a branch.
  - 4 VALID_UNSTABLE: prev_hold & valid & ~branch, and any of addr/rdata/err/err_plus2 differs from the captured value.
  - 5 ADDR_SEQ: valid & ~branch & exp_valid & (addr != exp_addr). Checked on every valid cycle, including the first valid after a branch.
  - 6 VALID_EARLY: valid & ~seen_branch. No valid is allowed before the first branch after reset.
  - 7 ERR_PLUS2: valid & ~branch & err & err_plus2 & (rdata[1:0]!=2'b11). err_plus2 is legal only for uncompressed instructions.
- Simultaneous events:
  - Rules are independent; several fail_o bits may pulse together.
  - A branch coinciding with hs updates exp_addr from branch_addr; the branch wins.
- fail_sticky_o[i] <= fail_sticky_o[i] | fail_o[i]; saturates, never clears except on reset.
- enable, invalidate, busy and branch_spec do not affect any rule.
- Invalidation does not reset exp_addr.

Optional Feature:
- Macro ICACHE_CORE_CHK_MSG_EN.
- Defined: each rising fail_o bit additionally issues a simulation $error naming the rule, with addr, exp_addr and the time. Synthesis ignores these.
- Undefined: no messages; flag outputs are identical in both builds.

Test Plan:
- Reset, branch to 0x100, valid addr 0x100 rdata 0x0000_0013 held 3 cycles, then ready=1 → hs; next valid addr 0x104 → fail_sticky_o stays 8'h00.
- Branch to 0x200, valid addr 0x200 rdata[1:0]=2'b01, hs; next valid addr 0x204 → fail_o[5] pulses one cycle later; expected next address was 0x202.
- valid=1 ready=0 addr 0x300, next cycle valid=0 with no branch → fail_o[3]=1. Repeat with branch in the drop cycle → no fail.
- valid held with ready=0 and rdata changing 0x13→0x93 → fail_o[4]=1; fail_sticky_o[4] stays 1 until rst_n low, then 0 asynchronously.
- branch=1 req=0 branch_addr 0x101 → fail_o[0] and fail_o[1] pulse together. CHECK_MASK=8'hFE → only fail_o[1] pulses.
- valid before any branch after reset → fail_o[6]. Valid with err=1, err_plus2=1, rdata[1:0]=2'b10 → fail_o[7].

Source files
------------

// File: rtl/ibex_icache_core_protocol_checker.sv
// Passive checker for the icache core-side fetch port: eight rules, registered pulses and sticky flags.
// Optional ICACHE_CORE_CHK_MSG_EN adds simulation $error messages; the flag outputs are the same either way.
module ibex_icache_core_protocol_checker #(
  parameter logic [7:0] CHECK_MASK = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        branch,
  input  logic        branch_spec,
  input  logic [31:0] branch_addr,
  input  logic        ready,
  input  logic        valid,
  input  logic [31:0] rdata,
  input  logic [31:0] addr,
  input  logic        err,
  input  logic        err_plus2,
  input  logic        enable,
  input  logic        invalidate,
  input  logic        busy,
  output logic [7:0]  fail_o,
  output logic [7:0]  fail_sticky_o,
  output logic        fail_any_o
);

  localparam int unsigned R_BRANCH_ALIGN  = 0;
  localparam int unsigned R_BRANCH_NO_REQ = 1;
  localparam int unsigned R_VALID_ALIGN   = 2;
  localparam int unsigned R_VALID_DROP    = 3;
  localparam int unsigned R_VALID_UNSTAB  = 4;
  localparam int unsigned R_ADDR_SEQ      = 5;
  localparam int unsigned R_VALID_EARLY   = 6;
  localparam int unsigned R_ERR_PLUS2     = 7;

  logic        hs;
  logic        valid_nb;
  logic        seen_branch;
  logic        exp_valid;
  logic [31:0] exp_addr;
  logic [31:0] next_addr;

  logic        prev_hold;
  logic [31:0] hold_addr;
  logic [31:0] hold_rdata;
  logic        hold_err;
  logic        hold_err_plus2;
  logic        hold_changed;

  logic [7:0]  rule;

  // These ports are part of the agent bundle but carry no rule.
  logic unused_obs;
  assign unused_obs = ^{branch_spec, enable, invalidate, busy};

  // A valid coinciding with a branch is discarded by the core, so it never counts as a handshake.
  assign valid_nb  = valid & ~branch;
  assign hs        = valid_nb & ready;
  assign next_addr = addr + ((rdata[1:0] == 2'b11) ? 32'd4 : 32'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_branch <= 1'b0;
      exp_valid   <= 1'b0;
      exp_addr    <= '0;
    end else if (branch) begin
      seen_branch <= 1'b1;
      exp_valid   <= 1'b1;
      exp_addr    <= branch_addr;
    end else if (hs) begin
      if (err) begin
        exp_valid <= 1'b0;
      end else begin
        exp_addr <= next_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hold      <= 1'b0;
      hold_addr      <= '0;
      hold_rdata     <= '0;
      hold_err       <= 1'b0;
      hold_err_plus2 <= 1'b0;
    end else begin
      prev_hold      <= valid_nb & ~ready;
      hold_addr      <= addr;
      hold_rdata     <= rdata;
      hold_err       <= err;
      hold_err_plus2 <= err_plus2;
    end
  end

  assign hold_changed = (addr != hold_addr) | (rdata != hold_rdata) |
                        (err != hold_err) | (err_plus2 != hold_err_plus2);

  always_comb begin
    rule                  = '0;
    rule[R_BRANCH_ALIGN]  = branch & branch_addr[0];
    rule[R_BRANCH_NO_REQ] = branch & ~req;
    rule[R_VALID_ALIGN]   = valid_nb & addr[0];
    rule[R_VALID_DROP]    = prev_hold & ~valid & ~branch;
    rule[R_VALID_UNSTAB]  = prev_hold & valid_nb & hold_changed;
    rule[R_ADDR_SEQ]      = valid_nb & exp_valid & (addr != exp_addr);
    rule[R_VALID_EARLY]   = valid & ~seen_branch;
    rule[R_ERR_PLUS2]     = valid_nb & err & err_plus2 & (rdata[1:0] != 2'b11);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_o        <= '0;
      fail_sticky_o <= '0;
    end else begin
      fail_o        <= rule & CHECK_MASK;
      fail_sticky_o <= fail_sticky_o | fail_o;
    end
  end

  assign fail_any_o = |fail_sticky_o;

`ifdef ICACHE_CORE_CHK_MSG_EN
  logic [7:0]  fail_q;
  logic [31:0] addr_q;
  logic [31:0] exp_addr_q;

  // Capture the values seen when the rule fired so the message matches the offending cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q     <= '0;
      addr_q     <= '0;
      exp_addr_q <= '0;
    end else begin
      fail_q     <= fail_o;
      addr_q     <= addr;
      exp_addr_q <= exp_addr;
    end
  end

  function automatic string rule_name(input int unsigned idx);
    case (idx)
      R_BRANCH_ALIGN:  return "BRANCH_ALIGN";
      R_BRANCH_NO_REQ: return "BRANCH_NO_REQ";
      R_VALID_ALIGN:   return "VALID_ALIGN";
      R_VALID_DROP:    return "VALID_DROP";
      R_VALID_UNSTAB:  return "VALID_UNSTABLE";
      R_ADDR_SEQ:      return "ADDR_SEQ";
      R_VALID_EARLY:   return "VALID_EARLY";
      default:         return "ERR_PLUS2";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (fail_o[i] && !fail_q[i]) begin
          $error("icache core protocol rule %s violated: addr=%08h exp_addr=%08h time=%0t",
                 rule_name(i), addr_q, exp_addr_q, $time);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ibex_icache_core_protocol_checker.sv
// Directed bench for the icache core-side protocol checker; a second instance runs with CHECK_MASK=8'hFE.
module tb_ibex_icache_core_protocol_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, branch, branch_spec, ready, valid, err, err_plus2;
  logic        enable, invalidate, busy;
  logic [31:0] branch_addr, rdata, addr;
  logic [7:0]  fail_o, fail_sticky_o, fail_o_m, fail_sticky_o_m;
  logic        fail_any_o, fail_any_o_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_icache_core_protocol_checker dut (
    .clk(clk), .rst_n(rst_n), .req(req), .branch(branch), .branch_spec(branch_spec),
    .branch_addr(branch_addr), .ready(ready), .valid(valid), .rdata(rdata), .addr(addr),
    .err(err), .err_plus2(err_plus2), .enable(enable), .invalidate(invalidate), .busy(busy),
    .fail_o(fail_o), .fail_sticky_o(fail_sticky_o), .fail_any_o(fail_any_o)
  );

  ibex_icache_core_protocol_checker #(.CHECK_MASK(8'hFE)) dut_m (
    .clk(clk), .rst_n(rst_n), .req(req), .branch(branch), .branch_spec(branch_spec),
    .branch_addr(branch_addr), .ready(ready), .valid(valid), .rdata(rdata), .addr(addr),
    .err(err), .err_plus2(err_plus2), .enable(enable), .invalidate(invalidate), .busy(busy),
    .fail_o(fail_o_m), .fail_sticky_o(fail_sticky_o_m), .fail_any_o(fail_any_o_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs applied 1 time unit after an edge are sampled at the next edge; outputs read 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 0; valid = 0; ready = 0; err = 0; err_plus2 = 0;
  endtask

  task automatic do_branch(input logic [31:0] target);
    idle();
    branch = 1; branch_addr = target;
    tick();
    branch = 0;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    branch = 0; valid = 1; addr = a; rdata = d; ready = rdy;
  endtask

  initial begin
    rst_n = 0; req = 1; branch_spec = 0; branch_addr = '0; rdata = '0; addr = '0;
    enable = 1; invalidate = 0; busy = 0;
    idle();
    repeat (3) tick();
    chk("reset_fail", {24'h0, fail_o}, 32'h0);
    chk("reset_sticky", {24'h0, fail_sticky_o}, 32'h0);
    chk("reset_any", {31'h0, fail_any_o}, 32'h0);
    rst_n = 1;
    tick();

    // Clean sequence: branch, held valid, handshake, sequential follow-on.
    do_branch(32'h100);
    chk("t1_branch", {24'h0, fail_o}, 32'h0);
    present(32'h100, 32'h13, 0);
    repeat (3) tick();
    chk("t1_hold", {24'h0, fail_o}, 32'h0);
    ready = 1; tick();
    chk("t1_hs", {24'h0, fail_o}, 32'h0);
    present(32'h104, 32'h13, 1); tick();
    idle(); tick();
    chk("t1_sticky", {24'h0, fail_sticky_o}, 32'h0);

    // Compressed instruction advances by 2.
    do_branch(32'h200);
    present(32'h200, 32'h01, 1); tick();
    chk("t2_first", {24'h0, fail_o}, 32'h0);
    present(32'h204, 32'h13, 1); tick();
    chk("t2_addr_seq", {24'h0, fail_o}, 32'h20);
    idle(); tick();
    chk("t2_one_cycle", {24'h0, fail_o}, 32'h0);

    // valid drop without branch, then with branch.
    do_branch(32'h300);
    present(32'h300, 32'h13, 0); tick();
    chk("t3_hold", {24'h0, fail_o}, 32'h0);
    idle(); tick();
    chk("t3_drop", {24'h0, fail_o}, 32'h08);
    present(32'h300, 32'h13, 0); tick();
    chk("t3_hold2", {24'h0, fail_o}, 32'h0);
    idle(); branch = 1; branch_addr = 32'h400; tick();
    branch = 0;
    chk("t3_drop_branch", {24'h0, fail_o}, 32'h0);

    // Instability while held.
    present(32'h400, 32'h13, 0); tick();
    chk("t4_hold", {24'h0, fail_o}, 32'h0);
    rdata = 32'h93; tick();
    chk("t4_unstable", {24'h0, fail_o}, 32'h10);
    idle(); branch = 1; branch_addr = 32'h500; tick();
    branch = 0;
    chk("t4_clean", {24'h0, fail_o}, 32'h0);
    chk("t4_sticky", {24'h0, fail_sticky_o}, 32'h38);
    chk("t4_any", {31'h0, fail_any_o}, 32'h1);

    // Misaligned branch without req; masked instance drops rule 0.
    req = 0; branch = 1; branch_addr = 32'h101; tick();
    branch = 0; req = 1;
    chk("t5_both", {24'h0, fail_o}, 32'h03);
    chk("t5_masked", {24'h0, fail_o_m}, 32'h02);
    tick();
    chk("t5_sticky", {24'h0, fail_sticky_o}, 32'h3B);
    chk("t5_sticky_masked", {24'h0, fail_sticky_o_m}, 32'h3A);

    // Asynchronous reset clears sticky without a clock edge.
    #2 rst_n = 0;
    #1;
    chk("t5_async_sticky", {24'h0, fail_sticky_o}, 32'h0);
    chk("t5_async_any", {31'h0, fail_any_o}, 32'h0);
    tick();
    rst_n = 1;
    tick();

    // Valid before any branch after reset.
    present(32'h10, 32'h13, 1); tick();
    chk("t6_early", {24'h0, fail_o}, 32'h40);
    idle(); tick();

    // err_plus2 on a compressed instruction; the error handshake disarms ADDR_SEQ.
    do_branch(32'h600);
    present(32'h600, 32'h12, 1); err = 1; err_plus2 = 1; tick();
    chk("t7_err_plus2", {24'h0, fail_o}, 32'h80);
    present(32'h700, 32'h13, 1); err = 0; err_plus2 = 0; tick();
    chk("t7_exp_invalid", {24'h0, fail_o}, 32'h0);

    // 32-bit wrap of the expected address.
    do_branch(32'hFFFF_FFFE);
    present(32'hFFFF_FFFE, 32'h13, 1); tick();
    present(32'h0000_0002, 32'h13, 1); tick();
    chk("t8_wrap", {24'h0, fail_o}, 32'h0);

    // Branch coinciding with a would-be handshake wins.
    present(32'h0000_0006, 32'h13, 1); branch = 1; branch_addr = 32'h800; tick();
    present(32'h800, 32'h13, 1); tick();
    chk("t9_branch_wins", {24'h0, fail_o}, 32'h0);
    idle(); tick();
    chk("t9_sticky", {24'h0, fail_sticky_o}, 32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
